// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2)[x] multiplier family: field constants,
// FSM state encoding and the digit-by-operand carry-less product.
package gf_pkg;

  localparam int unsigned GF128_W    = 128;
  localparam logic [GF128_W-1:0] GF128_POLY = 128'h87;

  // Widest operand the shared helper supports
  localparam int unsigned GF_MAX_W   = GF128_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RED  = 2'd2,
    ST_DONE = 2'd3
  } gf_state_e;

  // XOR of a shifted by every set bit of d; unused high bits of d tie off.
  function automatic logic [2*GF_MAX_W-1:0] clmul_digit(
    input logic [GF_MAX_W-1:0] a,
    input logic [GF_MAX_W-1:0] d
  );
    logic [2*GF_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < GF_MAX_W; i++) begin
      if (d[i]) r = r ^ ((2*GF_MAX_W)'(a) << i);
    end
    return r;
  endfunction

endpackage

// File: rtl/gf_clmul_serial_if.sv
// Operand/result handshake bundle for the serial carry-less multiplier.
interface gf_clmul_serial_if
  import gf_pkg::*;
#(
  parameter int unsigned W = GF128_W
) ();

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           in_reduce;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_prod;
  logic           out_reduced;

  modport master (
    output in_valid, in_a, in_b, in_reduce, out_ready,
    input  in_ready, out_valid, out_prod, out_reduced
  );

  modport slave (
    input  in_valid, in_a, in_b, in_reduce, out_ready,
    output in_ready, out_valid, out_prod, out_reduced
  );

endinterface

// File: rtl/gf_reduce_step.sv
// Combinational DIGIT-bit reduction slice: clears bits TOP down to TOP-DIGIT+1
// of a 2W-bit value by folding each set bit k back as POLY << (k-W).
module gf_reduce_step
  import gf_pkg::*;
#(
  parameter int unsigned W     = GF128_W,
  parameter int unsigned DIGIT = 8,
  parameter logic [W-1:0] POLY = W'(GF128_POLY),
  parameter int unsigned TOP   = 2*W-1
) (
  input  logic [2*W-1:0] acc_i,
  output logic [2*W-1:0] acc_c_o
);

  localparam logic [2*W-1:0] POLY_EXT = (2*W)'(POLY);

  logic [2*W-1:0] r;

  // Descending chain: a fold from bit k may set lower bits still in this slice
  always_comb begin
    r = acc_i;
    for (int unsigned j = 0; j < DIGIT; j++) begin
      if (r[TOP-j]) begin
        r        = r ^ (POLY_EXT << (TOP - j - W));
        r[TOP-j] = 1'b0;
      end
    end
  end

  assign acc_c_o = r;

endmodule

// File: rtl/gf_clmul_serial.sv
// Digit-serial carry-less multiplier with optional sequential reduction
// modulo x^W + POLY; area-lean replacement for the combinational multipliers.
module gf_clmul_serial
  import gf_pkg::*;
#(
  parameter int unsigned W     = GF128_W,
  parameter int unsigned DIGIT = 8,
  parameter logic [W-1:0] POLY = W'(GF128_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  gf_clmul_serial_if.slave bus
);

  localparam int unsigned N     = W / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  gf_state_e      state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           reduce_q, reduce_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;

  logic [2*W-1:0] mul_term_c;
  logic [2*W-1:0] red_acc_c;

  // b is shifted left each MUL cycle so the active digit is always the top one
  assign mul_term_c = (2*W)'(clmul_digit(GF_MAX_W'(a_q), GF_MAX_W'(b_q[W-1 -: DIGIT])));

  // acc is kept in a frame shifted left by DIGIT per RED cycle, so the slice
  // always works on the top DIGIT bits and needs no variable-index shifter.
  gf_reduce_step #(
    .W     (W),
    .DIGIT (DIGIT),
    .POLY  (POLY),
    .TOP   (2*W-1)
  ) u_reduce_step (
    .acc_i   (acc_q),
    .acc_c_o (red_acc_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      reduce_q    <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      reduce_q    <= reduce_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    reduce_d = reduce_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d      = bus.in_a;
          b_d      = bus.in_b;
          reduce_d = bus.in_reduce;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_MUL;
        end
      end
      ST_MUL: begin
        acc_d = (acc_q << DIGIT) ^ mul_term_c;
        b_d   = b_q << DIGIT;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = reduce_q ? ST_RED : ST_DONE;
        end
      end
      ST_RED: begin
        acc_d = red_acc_c << DIGIT;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Undo the frame shift: the remainder sits just below the last slice
          acc_d   = {{W{1'b0}}, red_acc_c[2*W-1-DIGIT -: W]};
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_prod    = acc_q;
  assign bus.out_reduced = reduce_q;

endmodule
